// File: rtl/riscv_pkg.sv
// Shared definitions for the in-order RISC-V pipeline: NOP encoding,
// fetch FSM states and the sequential pc increment.
package riscv_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetching_stage.sv
// Instruction fetch: owns the pc, keeps one cache read in flight and feeds the
// fetch/decode register. Optional misaligned-target trap: FETCH_MISALIGN_TRAP_EN.
module fetching_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL_FETCHING_STAGE,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        INS_CACHE_REQ,
  output logic [31:0] INS_CACHE_ADDRESS,
  input  logic        INS_CACHE_READY,
  input  logic        INS_CACHE_RVALID,
  input  logic [31:0] INS_CACHE_RDATA,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT,
  output logic        PC_VALID,
  output logic        INSTRUCTION_MISALIGNED
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic         parked_q, parked_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;
  logic         mis_q, mis_d;

  logic [31:0]  target;
  logic         mis_branch;
  logic         req;
  logic         accept;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = BRANCH_TARGET;
  assign mis_branch = BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
`else
  logic unused_target_bits;
  assign unused_target_bits = ^BRANCH_TARGET[1:0];
  assign target     = {BRANCH_TARGET[31:2], 2'b00};
  assign mis_branch = 1'b0;
`endif

  // A parked fetcher (after a misaligned trap) stays in FETCH but stops requesting.
  assign req    = (state_q == FETCH) && !parked_q;
  assign accept = req && INS_CACHE_READY;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    parked_d     = parked_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = STALL_FETCHING_STAGE ? valid_q : 1'b0;
    mis_d        = STALL_FETCHING_STAGE ? mis_q : 1'b0;

    if (BRANCH_TAKEN) begin
      // Redirect beats stall: the decode register is invalidated even when held.
      pc_d     = target;
      valid_d  = 1'b0;
      mis_d    = 1'b0;
      parked_d = mis_branch;
      case (state_q)
        FETCH: begin
          if (accept) begin
            state_d   = WAIT;
            discard_d = 1'b1;
          end
        end
        WAIT: begin
          if (INS_CACHE_RVALID) begin
            state_d   = FETCH;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = FETCH;
      endcase
      if (mis_branch) begin
        instr_d  = NOP;
        pc_out_d = BRANCH_TARGET;
        valid_d  = 1'b1;
        mis_d    = 1'b1;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (accept) state_d = WAIT;
        end
        WAIT: begin
          if (INS_CACHE_RVALID) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = FETCH;
            end else if (STALL_FETCHING_STAGE) begin
              hold_instr_d = INS_CACHE_RDATA;
              hold_pc_d    = pc_q;
              pc_d         = pc_q + PC_INC;
              state_d      = HOLD;
            end else begin
              instr_d  = INS_CACHE_RDATA;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              pc_d     = pc_q + PC_INC;
              state_d  = FETCH;
            end
          end
        end
        HOLD: begin
          if (!STALL_FETCHING_STAGE) begin
            instr_d  = hold_instr_q;
            pc_out_d = hold_pc_q;
            valid_d  = 1'b1;
            state_d  = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      parked_q     <= 1'b0;
      hold_instr_q <= NOP;
      hold_pc_q    <= 32'h0;
      instr_q      <= NOP;
      pc_out_q     <= 32'h0;
      valid_q      <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      parked_q     <= parked_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      mis_q        <= mis_d;
    end
  end

  assign INS_CACHE_REQ          = req;
  assign INS_CACHE_ADDRESS      = pc_q;
  assign INSTRUCTION            = instr_q;
  assign PC_OUT                 = pc_out_q;
  assign PC_VALID               = valid_q;
  assign INSTRUCTION_MISALIGNED = mis_q;

endmodule

// File: tb/tb_fetching_stage.sv
// Bench for fetching_stage: a single-outstanding cache model plus a program-order
// scoreboard (expected pc stream restarted by every redirect).
module tb_fetching_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic        INS_CACHE_REQ;
  logic [31:0] INS_CACHE_ADDRESS;
  logic        INS_CACHE_READY = 1'b0;
  logic        INS_CACHE_RVALID = 1'b0;
  logic [31:0] INS_CACHE_RDATA = 32'h0;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_OUT;
  logic        PC_VALID;
  logic        INSTRUCTION_MISALIGNED;

  fetching_stage #(.RESET_PC(RST_PC)) dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .STALL_FETCHING_STAGE   (STALL),
    .BRANCH_TAKEN           (BRANCH_TAKEN),
    .BRANCH_TARGET          (BRANCH_TARGET),
    .INS_CACHE_REQ          (INS_CACHE_REQ),
    .INS_CACHE_ADDRESS      (INS_CACHE_ADDRESS),
    .INS_CACHE_READY        (INS_CACHE_READY),
    .INS_CACHE_RVALID       (INS_CACHE_RVALID),
    .INS_CACHE_RDATA        (INS_CACHE_RDATA),
    .INSTRUCTION            (INSTRUCTION),
    .PC_OUT                 (PC_OUT),
    .PC_VALID               (PC_VALID),
    .INSTRUCTION_MISALIGNED (INSTRUCTION_MISALIGNED)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  // cache model
  bit          pending  = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_wait = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  int          ready_pct = 100;
  // scoreboard: next pc expected in program order
  logic [31:0] exp_pc = RST_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hfe010113;
    if (a == 32'h104) return 32'hfef42623;
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  // One clock cycle: drive inputs, model the cache, check outputs after the edge.
  task automatic cycle(input logic stall, input logic br, input logic [31:0] tgt);
    logic [31:0] p_instr, p_pc, addr;
    logic        p_valid, p_mis, req, acc, rv, mis;
    p_instr = INSTRUCTION;
    p_pc    = PC_OUT;
    p_valid = PC_VALID;
    p_mis   = INSTRUCTION_MISALIGNED;
    STALL         = stall;
    BRANCH_TAKEN  = br;
    BRANCH_TARGET = tgt;
    INS_CACHE_READY  = ($urandom_range(99) < ready_pct);
    rv               = pending && (pend_wait == 0);
    INS_CACHE_RVALID = rv;
    INS_CACHE_RDATA  = rv ? mem_word(pend_addr) : $urandom;
    #1;
    req  = INS_CACHE_REQ;
    addr = INS_CACHE_ADDRESS;
    acc  = req && INS_CACHE_READY;
    n_checks++;
    if (req && pending) begin
      n_fail++;
      $display("FAIL protocol: REQ=%0b while a response is outstanding (required 0)", req);
    end
    @(posedge CLK);
    #1;
    if (rv) pending = 1'b0;
    else if (pending && pend_wait > 0) pend_wait--;
    if (acc) begin
      pending   = 1'b1;
      pend_addr = addr;
      pend_wait = $urandom_range(lat_max, lat_min);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    mis = br && (tgt[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    n_checks++;
    if (br) begin
      if (mis) begin
        if ({PC_VALID, PC_OUT, INSTRUCTION, INSTRUCTION_MISALIGNED} !== {1'b1, tgt, NOP_W, 1'b1}) begin
          n_fail++;
          $display("FAIL sb_trap: got v=%0b pc=%h ins=%h mis=%0b, required v=1 pc=%h ins=%h mis=1",
                   PC_VALID, PC_OUT, INSTRUCTION, INSTRUCTION_MISALIGNED, tgt, NOP_W);
        end
      end else if (PC_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_redirect_bubble: PC_VALID=%0b, required 0", PC_VALID);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_pc = tgt;
`else
      exp_pc = {tgt[31:2], 2'b00};
`endif
    end else if (stall) begin
      if ({INSTRUCTION, PC_OUT, PC_VALID, INSTRUCTION_MISALIGNED} !== {p_instr, p_pc, p_valid, p_mis}) begin
        n_fail++;
        $display("FAIL sb_stall_hold: got ins=%h pc=%h v=%0b, required ins=%h pc=%h v=%0b",
                 INSTRUCTION, PC_OUT, PC_VALID, p_instr, p_pc, p_valid);
      end
    end else if (PC_VALID === 1'b1) begin
      if ({PC_OUT, INSTRUCTION, INSTRUCTION_MISALIGNED} !== {exp_pc, mem_word(exp_pc), 1'b0}) begin
        n_fail++;
        $display("FAIL sb_order: got pc=%h ins=%h mis=%0b, required pc=%h ins=%h mis=0",
                 PC_OUT, INSTRUCTION, INSTRUCTION_MISALIGNED, exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    STALL = 1'b0;
    BRANCH_TAKEN = 1'b0;
    INS_CACHE_READY = 1'b0;
    INS_CACHE_RVALID = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    pending = 1'b0;
    exp_pc  = RST_PC;
    n_checks++;
    if ({INSTRUCTION, PC_OUT, PC_VALID, INSTRUCTION_MISALIGNED} !== {NOP_W, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ins=%h pc=%h v=%0b mis=%0b, required ins=%h pc=0 v=0 mis=0",
               INSTRUCTION, PC_OUT, PC_VALID, INSTRUCTION_MISALIGNED, NOP_W);
    end
    n_checks++;
    if ({INS_CACHE_REQ, INS_CACHE_ADDRESS} !== {1'b1, RST_PC}) begin
      n_fail++;
      $display("FAIL reset_request: got req=%0b addr=%h, required req=1 addr=%h",
               INS_CACHE_REQ, INS_CACHE_ADDRESS, RST_PC);
    end
    RST = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_first_fetch();
    ready_pct = 100; lat_min = 0; lat_max = 0;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({INSTRUCTION, PC_OUT, PC_VALID} !== {32'hfe010113, 32'h100, 1'b1}) begin
      n_fail++;
      $display("FAIL first_fetch: got ins=%h pc=%h v=%0b, required ins=fe010113 pc=00000100 v=1",
               INSTRUCTION, PC_OUT, PC_VALID);
    end
    n_checks++;
    if ({INS_CACHE_REQ, INS_CACHE_ADDRESS} !== {1'b1, 32'h104}) begin
      n_fail++;
      $display("FAIL first_next_addr: got req=%0b addr=%h, required req=1 addr=00000104",
               INS_CACHE_REQ, INS_CACHE_ADDRESS);
    end
    $display("test_first_fetch done");
  endtask

  task automatic test_stall_hold();
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if ({INSTRUCTION, PC_OUT, PC_VALID, INS_CACHE_REQ} !== {32'hfe010113, 32'h100, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_capture: got ins=%h pc=%h v=%0b req=%0b, required ins=fe010113 pc=00000100 v=1 req=0",
               INSTRUCTION, PC_OUT, PC_VALID, INS_CACHE_REQ);
    end
    cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (INS_CACHE_REQ !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold_state: REQ=%0b while holding, required 0", INS_CACHE_REQ);
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({INSTRUCTION, PC_OUT, PC_VALID, INS_CACHE_ADDRESS} !== {32'hfef42623, 32'h104, 1'b1, 32'h108}) begin
      n_fail++;
      $display("FAIL stall_release: got ins=%h pc=%h v=%0b addr=%h, required ins=fef42623 pc=00000104 v=1 addr=00000108",
               INSTRUCTION, PC_OUT, PC_VALID, INS_CACHE_ADDRESS);
    end
    $display("test_stall_hold done");
  endtask

  task automatic test_branch_wait();
    lat_min = 1; lat_max = 1;
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h200);
    n_checks++;
    if ({PC_VALID, INS_CACHE_REQ} !== 2'b00) begin
      n_fail++;
      $display("FAIL branch_wait_bubble: got v=%0b req=%0b, required v=0 req=0", PC_VALID, INS_CACHE_REQ);
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({PC_VALID, INS_CACHE_REQ, INS_CACHE_ADDRESS} !== {1'b0, 1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL branch_wait_drop: got v=%0b req=%0b addr=%h, required v=0 req=1 addr=00000200",
               PC_VALID, INS_CACHE_REQ, INS_CACHE_ADDRESS);
    end
    lat_min = 0; lat_max = 0;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({PC_VALID, PC_OUT} !== {1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL branch_wait_target: got v=%0b pc=%h, required v=1 pc=00000200", PC_VALID, PC_OUT);
    end
    $display("test_branch_wait done");
  endtask

  task automatic test_branch_hold();
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if ({PC_VALID, INS_CACHE_REQ} !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_setup: got v=%0b req=%0b, required v=1 req=0", PC_VALID, INS_CACHE_REQ);
    end
    cycle(1'b1, 1'b1, 32'h300);
    n_checks++;
    if ({PC_VALID, INS_CACHE_REQ, INS_CACHE_ADDRESS} !== {1'b0, 1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL hold_branch: got v=%0b req=%0b addr=%h, required v=0 req=1 addr=00000300",
               PC_VALID, INS_CACHE_REQ, INS_CACHE_ADDRESS);
    end
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({PC_VALID, PC_OUT} !== {1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL hold_dropped: got v=%0b pc=%h, required v=1 pc=00000300", PC_VALID, PC_OUT);
    end
    $display("test_branch_hold done");
  endtask

  task automatic test_pc_wrap();
    bit found = 1'b0;
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (PC_VALID === 1'b1 && PC_OUT === 32'hFFFF_FFFC) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wrap_timeout: pc FFFFFFFC never delivered within 20 cycles (required delivery)");
    end else if ({INS_CACHE_REQ, INS_CACHE_ADDRESS} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_addr: got req=%0b addr=%h, required req=1 addr=00000000",
               INS_CACHE_REQ, INS_CACHE_ADDRESS);
    end
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    $display("test_pc_wrap done");
  endtask

  task automatic test_misaligned();
    cycle(1'b0, 1'b1, 32'h202);
`ifdef FETCH_MISALIGN_TRAP_EN
    n_checks++;
    if ({PC_OUT, INSTRUCTION_MISALIGNED, INS_CACHE_REQ} !== {32'h202, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL misaligned_trap: got pc=%h mis=%0b req=%0b, required pc=00000202 mis=1 req=0",
               PC_OUT, INSTRUCTION_MISALIGNED, INS_CACHE_REQ);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (INS_CACHE_REQ !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned_parked: REQ=%0b while parked, required 0", INS_CACHE_REQ);
      end
    end
    cycle(1'b0, 1'b1, 32'h400);
`else
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        cycle(1'b0, 1'b0, 32'h0);
        if (INS_CACHE_REQ === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL misaligned_timeout: no request within 10 cycles (required one)");
      end else if ({INS_CACHE_ADDRESS, INSTRUCTION_MISALIGNED} !== {32'h200, 1'b0}) begin
        n_fail++;
        $display("FAIL misaligned_forced: got addr=%h mis=%0b, required addr=00000200 mis=0",
                 INS_CACHE_ADDRESS, INSTRUCTION_MISALIGNED);
      end
    end
`endif
    $display("test_misaligned done");
  endtask

  task automatic test_random();
    logic        st, br;
    logic [31:0] tgt;
    ready_pct = 75; lat_min = 0; lat_max = 2;
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(99) < 25);
      br  = ($urandom_range(99) < 4);
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom_range(3) << 2);
      else                        tgt = $urandom_range(1023) << 2;
`ifndef FETCH_MISALIGN_TRAP_EN
      tgt = tgt | $urandom_range(3);
`endif
      cycle(st, br, tgt);
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall_hold();
    test_branch_wait();
    test_branch_hold();
    test_pc_wrap();
    test_misaligned();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
